asym_ram_rd_sched: RTL and testbench



---
 rtl/asym_ram_rd_sched.sv | 184 ++++++++++++++++++
 tb/tb_asym_ram_rd_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asym_ram_rd_sched.sv
// Read-side scheduler for the wide port of the asymmetric sample/envelope RAM.
// It arbitrates burst requests from NREQ requesters and drives one RAM read address per cycle.
// Each returned word is tagged {valid, id, last}. The tag is aligned to the fixed RAM read latency.
// Optional feature macro: ASYM_RD_SCHED_ROUND_ROBIN_EN selects round-robin arbitration.
// When the macro is undefined, arbitration is fixed priority and the lowest index wins.
module asym_ram_rd_sched #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned ADDRWIDTHB = 10,
  parameter int unsigned DATAWIDTHB = 512,
  parameter int unsigned LENWIDTH   = 8,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*ADDRWIDTHB-1:0] req_addr,
  input  logic [NREQ*LENWIDTH-1:0]   req_len,
  output logic [NREQ-1:0]            ack,
  output logic                       busy,
  output logic [ADDRWIDTHB-1:0]      ram_addr,
  input  logic [DATAWIDTHB-1:0]      ram_do,
  output logic [DATAWIDTHB-1:0]      dout,
  output logic                       dout_valid,
  output logic [$clog2(NREQ)-1:0]    dout_id,
  output logic                       dout_last
);

  localparam int unsigned IdW = $clog2(NREQ);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e                state_q, state_d;
  logic [ADDRWIDTHB-1:0] addr_q, addr_d;
  logic [LENWIDTH-1:0]   cnt_q, cnt_d;
  logic [IdW-1:0]        id_q, id_d;
  logic [NREQ-1:0]       ack_q, ack_d;

  logic                  grant_valid;
  logic [IdW-1:0]        grant_id;
  logic [ADDRWIDTHB-1:0] sel_addr;
  logic [LENWIDTH-1:0]   sel_len;

  logic                  tok_vld;
  logic                  tok_last;
  logic [IdW-1:0]        tok_id;

  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [RD_LATENCY-1:0] pipe_last_q;
  logic [IdW-1:0]        pipe_id_q [RD_LATENCY];

`ifdef ASYM_RD_SCHED_ROUND_ROBIN_EN
  logic [IdW-1:0] rr_ptr_q;
  logic [IdW-1:0] rr_idx;
  logic           rr_found;

  // Round-robin winner: the first asserted request at or after the pointer, wrapping around.
  always_comb begin
    grant_valid = |req;
    grant_id    = '0;
    rr_found    = 1'b0;
    rr_idx      = rr_ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        grant_id = rr_idx;
      end
      rr_idx = (rr_idx == IdW'(NREQ - 1)) ? '0 : rr_idx + 1'b1;
    end
  end

  // The pointer moves past each winner so that the winner gets the lowest priority next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (state_q == StIdle && grant_valid) begin
      rr_ptr_q <= (grant_id == IdW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end
`else
  // Fixed-priority winner: the lowest asserted index wins.
  always_comb begin
    grant_valid = |req;
    grant_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) grant_id = IdW'(i);
    end
  end
`endif

  // Select the winner's start address and length.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IdW'(i)) begin
        sel_addr = req_addr[i*ADDRWIDTHB +: ADDRWIDTHB];
        sel_len  = req_len[i*LENWIDTH +: LENWIDTH];
      end
    end
  end

  // FSM next state: latch the request in idle, then issue one beat per cycle during the burst.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    ack_d    = '0;
    tok_vld  = 1'b0;
    tok_last = 1'b0;
    tok_id   = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d         = StBurst;
          addr_d          = sel_addr;
          cnt_d           = sel_len;
          id_d            = grant_id;
          ack_d[grant_id] = 1'b1;
        end
      end
      StBurst: begin
        tok_vld  = 1'b1;
        tok_id   = id_q;
        tok_last = (cnt_q == '0);
        if (tok_last) begin
          // Hold the address on the last beat so that ram_addr keeps it while idle.
          state_d = StIdle;
        end else begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and burst registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      ack_q   <= ack_d;
    end
  end

  // Token shift pipeline. Its depth matches the RAM read latency, so the tag lines up with ram_do.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_id_q[i] <= '0;
    end else begin
      pipe_vld_q[0]  <= tok_vld;
      pipe_last_q[0] <= tok_last;
      pipe_id_q[0]   <= tok_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
        pipe_id_q[i]   <= pipe_id_q[i-1];
      end
    end
  end

  // Outputs.
  always_comb begin
    ack        = ack_q;
    ram_addr   = addr_q;
    busy       = (state_q == StBurst) | (|pipe_vld_q);
    dout       = ram_do;
    dout_valid = pipe_vld_q[RD_LATENCY-1];
    dout_id    = pipe_id_q[RD_LATENCY-1];
    dout_last  = pipe_last_q[RD_LATENCY-1];
  end

endmodule

// File: tb/tb_asym_ram_rd_sched.sv
// Self-checking bench for asym_ram_rd_sched with a scoreboard of expected read beats.
// The arbitration scenario depends on the build: round-robin when ASYM_RD_SCHED_ROUND_ROBIN_EN
// is defined, fixed priority otherwise.
module tb_asym_ram_rd_sched;

  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int DW   = 512;
  localparam int LW   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_do;
  logic [DW-1:0]     dout;
  logic              dout_valid;
  logic [1:0]        dout_id;
  logic              dout_last;

  asym_ram_rd_sched #(
    .NREQ(NREQ), .ADDRWIDTHB(AW), .DATAWIDTHB(DW), .LENWIDTH(LW), .RD_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len), .ack(ack),
    .busy(busy), .ram_addr(ram_addr), .ram_do(ram_do), .dout(dout), .dout_valid(dout_valid),
    .dout_id(dout_id), .dout_last(dout_last)
  );

  always #5 clk = ~clk;

  // RAM model with a two-cycle read latency and preloaded contents.
  logic [DW-1:0] mem [1024];
  logic [AW-1:0] ra1, ra2;
  always @(posedge clk) begin
    ra1 <= ram_addr;
    ra2 <= ra1;
  end
  assign ram_do = mem[ra2];

  typedef struct {
    int       id;
    logic [AW-1:0] addr;
    bit       last;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int beat_cnt = 0;
  int last_cnt = 0;
  bit prev_ack = 1'b0;
  int exp_order[8];
  int nexp;

  // Scoreboard and ack monitor.
  always @(negedge clk) begin
    beat_t e;
    if (|ack) begin
      ack_cnt++;
      checks++;
      if (!$onehot(ack) || prev_ack) begin
        errors++;
        $display("FAIL ack_pulse: ack=%b prev_ack=%0d, required one-hot and not consecutive",
                 ack, prev_ack);
      end
    end
    prev_ack = |ack;
    if (dout_valid) begin
      beat_cnt++;
      if (dout_last) last_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: dout_valid=1 id=%0d with empty scoreboard", dout_id);
      end else begin
        e = sb.pop_front();
        if (dout_id !== 2'(e.id) || dout_last !== e.last || dout !== mem[e.addr]) begin
          errors++;
          $display("FAIL beat: id=%0d last=%0d data_ok=%0d, required id=%0d last=%0d addr=%h",
                   dout_id, dout_last, (dout === mem[e.addr]), e.id, e.last, e.addr);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL idle: busy=%b pending=%0d, required busy=0 pending=0", busy, sb.size());
    end
    sb.delete();
  endtask

  task automatic issue(input int id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    logic [AW-1:0] ea;
    @(posedge clk); #1;
    req_addr[id*AW +: AW] = addr;
    req_len[id*LW +: LW]  = len;
    req[id] = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      ea = addr + AW'(b);
      sb.push_back('{id, ea, (b == int'(len))});
    end
    @(negedge clk);
    checks++;
    if (ack !== '0) begin
      errors++;
      $display("FAIL ack_early: ack=%b, required 0000", ack);
    end
    @(negedge clk);
    checks++;
    if (ack[id] !== 1'b1 || ram_addr !== addr) begin
      errors++;
      $display("FAIL ack_first: ack=%b ram_addr=%h, required ack[%0d]=1 ram_addr=%h",
               ack, ram_addr, id, addr);
    end
    req[id] = 1'b0;
    for (int b = 1; b <= int'(len); b++) begin
      @(negedge clk);
      ea = addr + AW'(b);
      checks++;
      if (ram_addr !== ea || busy !== 1'b1) begin
        errors++;
        $display("FAIL addr_seq: beat %0d ram_addr=%h busy=%b, required %h busy=1",
                 b, ram_addr, busy, ea);
      end
    end
    wait_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    req_addr = '0;
    req_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== '0 || busy !== 1'b0 || ram_addr !== '0 || dout_valid !== 1'b0 ||
        dout_id !== '0 || dout_last !== 1'b0) begin
      errors++;
      $display("FAIL reset: ack=%b busy=%b addr=%h dv=%b id=%0d last=%b, required all zero",
               ack, busy, ram_addr, dout_valid, dout_id, dout_last);
    end
  endtask

  task automatic test_single();
    issue(1, 10'h010, 8'd3);
  endtask

  task automatic test_wrap();
    issue(2, 10'h3FE, 8'd3);
  endtask

  // Each requester gets a fixed 2-beat burst. A requester is re-raised after its ack
  // only if it appears again later in the expected grant order.
  task automatic run_arb(input logic [NREQ-1:0] init_mask);
    int grants = 0;
    int cyc = 0;
    int last_ack = 0;
    int w;
    logic [NREQ-1:0] reraise = '0;
    logic [AW-1:0] a;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = AW'(10'h100 + i * 32);
      req_len[i*LW +: LW]  = 8'd1;
    end
    for (int g = 0; g < nexp; g++) begin
      for (int b = 0; b < 2; b++) begin
        a = AW'(10'h100 + exp_order[g] * 32 + b);
        sb.push_back('{exp_order[g], a, (b == 1)});
      end
    end
    req = init_mask;
    while (grants < nexp && cyc < 200) begin
      @(negedge clk);
      cyc++;
      req = req | reraise;
      reraise = '0;
      if (|ack) begin
        w = 0;
        for (int i = NREQ - 1; i >= 0; i--) if (ack[i]) w = i;
        checks++;
        if (w != exp_order[grants]) begin
          errors++;
          $display("FAIL arb_order: grant %0d went to %0d, required %0d", grants, w,
                   exp_order[grants]);
        end
        if (grants > 0) begin
          checks++;
          if (cyc - last_ack != 3) begin
            errors++;
            $display("FAIL arb_gap: %0d cycles between acks, required 3", cyc - last_ack);
          end
        end
        last_ack = cyc;
        req[w] = 1'b0;
        for (int g = grants + 1; g < nexp; g++) if (exp_order[g] == w) reraise[w] = 1'b1;
        grants++;
        if (grants == nexp) req = '0;
      end
    end
    req = '0;
    checks++;
    if (grants != nexp) begin
      errors++;
      $display("FAIL arb_timeout: %0d grants seen, required %0d", grants, nexp);
    end
    wait_idle();
  endtask

`ifdef ASYM_RD_SCHED_ROUND_ROBIN_EN
  task automatic test_round_robin();
    nexp = 5;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
    run_arb(4'b1111);
  endtask
`else
  task automatic test_fixed_priority();
    nexp = 4;
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 2;
    run_arb(4'b0101);
  endtask
`endif

  task automatic test_reset_mid_burst();
    logic [AW-1:0] a;
    int n = 0;
    @(posedge clk); #1;
    req_addr[0 +: AW] = 10'h200;
    req_len[0 +: LW]  = 8'd15;
    req[0] = 1'b1;
    for (int b = 0; b < 16; b++) begin
      a = AW'(10'h200 + b);
      sb.push_back('{0, a, (b == 15)});
    end
    do begin
      @(negedge clk);
      n++;
    end while (!ack[0] && n < 10);
    req[0] = 1'b0;
    checks++;
    if (ack[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ack: ack=%b, required ack[0]=1", ack);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || ram_addr !== '0) begin
      errors++;
      $display("FAIL rst_mid: dv=%b busy=%b ram_addr=%h, required 0 0 000",
               dout_valid, busy, ram_addr);
    end
    issue(3, 10'h040, 8'd2);
  endtask

  task automatic test_max_len();
    int a0 = ack_cnt;
    int b0 = beat_cnt;
    int l0 = last_cnt;
    issue(0, 10'h080, 8'd255);
    checks++;
    if (ack_cnt - a0 != 1 || beat_cnt - b0 != 256 || last_cnt - l0 != 1) begin
      errors++;
      $display("FAIL max_len: acks=%0d beats=%0d lasts=%0d, required 1 256 1",
               ack_cnt - a0, beat_cnt - b0, last_cnt - l0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      for (int w = 0; w < DW / 32; w++) mem[i][w*32 +: 32] = $urandom;
    end
    test_reset();
    test_single();
    test_wrap();
`ifdef ASYM_RD_SCHED_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_reset_mid_burst();
    test_max_len();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
